// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the RISC-V multicycle controller:
//   - FSM state encodings
//   - opcode constants for the supported instructions
//   - ALUControl, ALUOp, ResultSrc, ALUSrcA/B and ImmSrc select encodings
//   - the per-state control word and its Moore decode
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (TRAP state reachable).
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       pcupdate;
    logic       branch;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore control word for a state; anything not set stays 0.
  function automatic ctrl_t ctrl_for_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite   = 1'b1;
        c.alusrca   = SRCA_PC;
        c.alusrcb   = SRCB_FOUR;
        c.aluop     = ALUOP_ADD;
        c.resultsrc = RES_ALURESULT;
        c.pcupdate  = 1'b1;
      end
      S_DECODE: begin
        c.alusrca = SRCA_OLDPC;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alusrca = SRCA_RD1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMREAD: begin
        c.resultsrc = RES_ALUOUT;
        c.adrsrc    = 1'b1;
      end
      S_MEMWB: begin
        c.resultsrc = RES_DATA;
        c.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        c.resultsrc = RES_ALUOUT;
        c.adrsrc    = 1'b1;
        c.memwrite  = 1'b1;
      end
      S_EXECUTER: begin
        c.alusrca = SRCA_RD1;
        c.alusrcb = SRCB_RD2;
        c.aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alusrca = SRCA_RD1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.resultsrc = RES_ALUOUT;
        c.regwrite  = 1'b1;
      end
      S_BEQ: begin
        c.alusrca   = SRCA_RD1;
        c.alusrcb   = SRCB_RD2;
        c.aluop     = ALUOP_SUB;
        c.resultsrc = RES_ALUOUT;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alusrca   = SRCA_OLDPC;
        c.alusrcb   = SRCB_FOUR;
        c.aluop     = ALUOP_ADD;
        c.resultsrc = RES_ALUOUT;
        c.pcupdate  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU operation decode for the multicycle controller.
// Ports:
//   aluop_i      ALUOp from the FSM (00 add, 01 sub, 10 by funct3)
//   funct3_i     instr[14:12]
//   funct7b5_i   instr[30]
//   op5_i        instr[5], separates R-type (sub possible) from I-type
//   alucontrol_o ALU operation select
// ---------------------------------------------------------------------------
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // addi has funct7b5 as an immediate bit, so only R-type may subtract
          3'b000:  alucontrol_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol_o = ALU_SLT;
          3'b110:  alucontrol_o = ALU_OR;
          3'b111:  alucontrol_o = ALU_AND;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Main controller of the RISC-V multicycle datapath (lw, sw, R, I-ALU, beq,
// jal). Sequences the instruction phases, decodes ALU operation and
// immediate type, and drives the register file write enable.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN -- unknown opcodes lock
// the FSM in TRAP with illegal_instr high until reset.
//
// Ports:
//   clk, reset     clock (rising edge), async active-high reset
//   op, funct3, funct7b5, zero   instruction fields and ALU zero flag
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath strobes/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc   mux/ALU selects
//   state          current state (debug)
//   illegal_instr  unknown opcode trapped
//
// state      | meaning
// FETCH (0)  | read instruction, PC += 4
// DECODE (1) | read registers, compute branch target
// MEMADR (2) | compute load/store address
// MEMREAD(3) | read data memory
// MEMWB (4)  | write load data to register file
// MEMWRITE(5)| write data memory
// EXECUTER(6)| R-type ALU operation
// EXECUTEI(7)| I-type ALU operation
// ALUWB (8)  | write ALU result to register file
// BEQ (9)    | compare, branch on zero
// JAL (10)   | PC = target, compute link address
// TRAP (11)  | unknown opcode, held until reset (optional)
// ---------------------------------------------------------------------------
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic [STATE_W-1:0] state,
  output logic               illegal_instr
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // The control word is registered alongside the state, precomputed from
  // the next state so that it always matches state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for_state(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for_state(state_d);
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= (state_d == S_TRAP);
  end
  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

  // Strobes are gated by reset directly so an aborted instruction never
  // emits a partial write while reset is held.
  assign PCWrite   = ~reset & (ctrl_q.pcupdate | (ctrl_q.branch & zero));
  assign IRWrite   = ~reset & ctrl_q.irwrite;
  assign MemWrite  = ~reset & ctrl_q.memwrite;
  assign RegWrite  = ~reset & ctrl_q.regwrite;
  assign AdrSrc    = ctrl_q.adrsrc;
  assign ResultSrc = ctrl_q.resultsrc;
  assign ALUSrcA   = ctrl_q.alusrca;
  assign ALUSrcB   = ctrl_q.alusrcb;
  assign state     = STATE_W'(state_q);

  alu_decoder u_alu_decoder (
    .aluop_i      (ctrl_q.aluop),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .op5_i        (op[5]),
    .alucontrol_o (ALUControl)
  );

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BEQ:      ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      default:     ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Directed table-driven bench for multicycle_control_fsm. Rows are applied
// one per cycle starting at reset release; expected outputs are
// hand-derived per state. Hand sequences cover reset mid-instruction and
// the unknown-opcode behaviour (with or without MC_CTRL_ILLEGAL_TRAP_EN).
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .state(state), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rsrc, asa, asb;
    logic [2:0] aluc;
    logic [1:0] imm;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    out_t       exp;
  } vec_t;

  vec_t tbl [64];
  int   n_vec = 0;
  int   total = 0;
  int   bad   = 0;

  function automatic out_t o(input int st, input int pcw, input int adr,
                             input int mw, input int irw, input int rw,
                             input int rsrc, input int asa, input int asb,
                             input int aluc, input int imm);
    out_t r;
    r.st = 4'(st); r.pcw = 1'(pcw); r.adr = 1'(adr); r.mw = 1'(mw);
    r.irw = 1'(irw); r.rw = 1'(rw); r.rsrc = 2'(rsrc); r.asa = 2'(asa);
    r.asb = 2'(asb); r.aluc = 3'(aluc); r.imm = 2'(imm); r.ill = 1'b0;
    return r;
  endfunction

  function automatic out_t actual();
    out_t r;
    r.st = state; r.pcw = PCWrite; r.adr = AdrSrc; r.mw = MemWrite;
    r.irw = IRWrite; r.rw = RegWrite; r.rsrc = ResultSrc; r.asa = ALUSrcA;
    r.asb = ALUSrcB; r.aluc = ALUControl; r.imm = ImmSrc; r.ill = illegal_instr;
    return r;
  endfunction

  task automatic add(input logic [6:0] vop, input int f3, input int f7,
                     input int z, input out_t e);
    tbl[n_vec].op  = vop;
    tbl[n_vec].f3  = 3'(f3);
    tbl[n_vec].f7  = 1'(f7);
    tbl[n_vec].z   = 1'(z);
    tbl[n_vec].exp = e;
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // lw: 5 cycles
    add(LW,2,0,0, o(0,1,0,0,1,0,2,0,2,0,0));
    add(LW,2,0,0, o(1,0,0,0,0,0,0,1,1,0,0));
    add(LW,2,0,0, o(2,0,0,0,0,0,0,2,1,0,0));
    add(LW,2,0,0, o(3,0,1,0,0,0,0,0,0,0,0));
    add(LW,2,0,0, o(4,0,0,0,0,1,1,0,0,0,0));
    // R-type sub
    add(RT,0,1,0, o(0,1,0,0,1,0,2,0,2,0,0));
    add(RT,0,1,0, o(1,0,0,0,0,0,0,1,1,0,0));
    add(RT,0,1,0, o(6,0,0,0,0,0,0,2,0,1,0));
    add(RT,0,1,0, o(8,0,0,0,0,1,0,0,0,0,0));
    // R-type or
    add(RT,6,0,0, o(0,1,0,0,1,0,2,0,2,0,0));
    add(RT,6,0,0, o(1,0,0,0,0,0,0,1,1,0,0));
    add(RT,6,0,0, o(6,0,0,0,0,0,0,2,0,3,0));
    add(RT,6,0,0, o(8,0,0,0,0,1,0,0,0,0,0));
    // addi with instr[30]=1 must still add
    add(IT,0,1,0, o(0,1,0,0,1,0,2,0,2,0,0));
    add(IT,0,1,0, o(1,0,0,0,0,0,0,1,1,0,0));
    add(IT,0,1,0, o(7,0,0,0,0,0,0,2,1,0,0));
    add(IT,0,1,0, o(8,0,0,0,0,1,0,0,0,0,0));
    // slti
    add(IT,2,0,0, o(0,1,0,0,1,0,2,0,2,0,0));
    add(IT,2,0,0, o(1,0,0,0,0,0,0,1,1,0,0));
    add(IT,2,0,0, o(7,0,0,0,0,0,0,2,1,5,0));
    add(IT,2,0,0, o(8,0,0,0,0,1,0,0,0,0,0));
    // beq taken
    add(BQ,0,0,1, o(0,1,0,0,1,0,2,0,2,0,2));
    add(BQ,0,0,1, o(1,0,0,0,0,0,0,1,1,0,2));
    add(BQ,0,0,1, o(9,1,0,0,0,0,0,2,0,1,2));
    // beq not taken
    add(BQ,0,0,0, o(0,1,0,0,1,0,2,0,2,0,2));
    add(BQ,0,0,0, o(1,0,0,0,0,0,0,1,1,0,2));
    add(BQ,0,0,0, o(9,0,0,0,0,0,0,2,0,1,2));
    // sw
    add(SW,2,0,0, o(0,1,0,0,1,0,2,0,2,0,1));
    add(SW,2,0,0, o(1,0,0,0,0,0,0,1,1,0,1));
    add(SW,2,0,0, o(2,0,0,0,0,0,0,2,1,0,1));
    add(SW,2,0,0, o(5,0,1,1,0,0,0,0,0,0,1));
    // jal
    add(JL,0,0,0, o(0,1,0,0,1,0,2,0,2,0,3));
    add(JL,0,0,0, o(1,0,0,0,0,0,0,1,1,0,3));
    add(JL,0,0,0, o(10,1,0,0,0,0,0,1,2,0,3));
    add(JL,0,0,0, o(8,0,0,0,0,1,0,0,0,0,3));
    add(JL,0,0,0, o(0,1,0,0,1,0,2,0,2,0,3));

    reset = 1'b1; op = LW; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    // in reset: FETCH selects, strobes forced low
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_strobes", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
    chk("reset_selects", {24'd0, ResultSrc, ALUSrcA, ALUSrcB, 1'b0, illegal_instr},
        {24'd0, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < n_vec; i++) begin
      op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7; zero = tbl[i].z;
      #1;
      chk($sformatf("vec%0d", i), 32'(actual()), 32'(tbl[i].exp));
      @(negedge clk);
    end

    // reset during MEMREAD of lw
    op = LW; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_in_memread", {27'd0, state, AdrSrc}, {27'd0, 4'd3, 1'b1});
    reset = 1'b1;
    #1;
    chk("midrst_async_state", {28'd0, state}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("midrst_hold%0d", k), {27'd0, state, RegWrite}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_release_fetch", {27'd0, state, IRWrite}, {27'd0, 4'd0, 1'b1});
    @(negedge clk);
    #1;
    chk("midrst_then_decode", {27'd0, state, RegWrite}, {27'd0, 4'd1, 1'b0});

    // unknown opcode
    reset = 1'b1; op = 7'b0000000; funct3 = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("illop_fetch", {28'd0, state}, 32'd0);
    @(negedge clk);
    #1;
    chk("illop_decode", {27'd0, state, illegal_instr}, {27'd0, 4'd1, 1'b0});
    @(negedge clk);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("trap_hold%0d", k),
          {26'd0, state, illegal_instr, PCWrite, IRWrite, MemWrite, RegWrite},
          {26'd0, 4'd11, 1'b1, 4'b0000});
      @(negedge clk);
    end
`else
    #1;
    chk("illop_back_to_fetch", {26'd0, state, illegal_instr, IRWrite, PCWrite},
        {26'd0, 4'd0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    #1;
    chk("illop_decode_again", {27'd0, state, illegal_instr}, {27'd0, 4'd1, 1'b0});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
